// File: rtl/mult_div.sv
// mult_div: multi-cycle multiply/divide unit with HI/LO registers, MADD and mthi/mtlo.
// Results are held in a pending register and committed to HI/LO when the busy window ends.
module mult_div #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  M_D_Cal,
   input  logic        is_signed,
   input  logic [1:0]  Other_Reg_Wr,
   input  logic [1:0]  M_D_Read,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        start,
   output logic        busy,
   output logic [31:0] MD_out
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [1:0] CAL_MULT = 2'b01;
   localparam logic [1:0] CAL_DIV  = 2'b10;
   localparam logic [1:0] CAL_MADD = 2'b11;
   localparam logic [1:0] WR_LO    = 2'b01;
   localparam logic [1:0] WR_HI    = 2'b10;
   localparam logic [1:0] RD_LO    = 2'b01;
   localparam logic [1:0] RD_HI    = 2'b10;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic [31:0]        p_hi_q, p_hi_d, p_lo_q, p_lo_d;
   logic               div_zero_q, div_zero_d;

   logic               accept;
   logic [63:0]        a_ext, b_ext, mul_prod, madd_prod, res;
   logic [31:0]        a_mag, b_mag, q_mag, r_mag, q_div, r_div;

   assign accept = (M_D_Cal != 2'b00) && (state_q == S_IDLE) && !reset;
   assign start  = accept;
   assign busy   = (state_q == S_RUN);

   // Read mux over committed HI/LO only.
   always_comb begin
      MD_out = 32'd0;
      if (M_D_Read == RD_LO) MD_out = lo_q;
      else if (M_D_Read == RD_HI) MD_out = hi_q;
   end

   // Result of the command presented this cycle; only captured on acceptance.
   always_comb begin
      a_ext     = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
      b_ext     = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
      mul_prod  = a_ext * b_ext;
      madd_prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      // Signed division via magnitudes keeps -2^31 / -1 well defined.
      a_mag     = (is_signed && A[31]) ? 32'(-A) : A;
      b_mag     = (is_signed && B[31]) ? 32'(-B) : B;
      if (b_mag == 32'd0) b_mag = 32'd1;
      q_mag     = a_mag / b_mag;
      r_mag     = a_mag % b_mag;
      q_div     = (is_signed && (A[31] ^ B[31])) ? 32'(-q_mag) : q_mag;
      r_div     = (is_signed && A[31]) ? 32'(-r_mag) : r_mag;
      case (M_D_Cal)
         CAL_MULT: res = mul_prod;
         CAL_DIV:  res = {r_div, q_div};
         CAL_MADD: res = {hi_q, lo_q} + madd_prod;
         default:  res = {hi_q, lo_q};
      endcase
   end

   // Next-state: accept command or move-to when idle, count down and commit when running.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      p_hi_d     = p_hi_q;
      p_lo_d     = p_lo_q;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_RUN;
               p_hi_d     = res[63:32];
               p_lo_d     = res[31:0];
               div_zero_d = (M_D_Cal == CAL_DIV) && (B == 32'd0);
               cnt_d      = (M_D_Cal == CAL_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (Other_Reg_Wr == WR_LO) begin
               lo_d = A;
            end else if (Other_Reg_Wr == WR_HI) begin
               hi_d = A;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               if (!div_zero_q) begin
                  hi_d = p_hi_q;
                  lo_d = p_lo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset that also aborts any running operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         p_hi_q     <= 32'd0;
         p_lo_q     <= 32'd0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         p_hi_q     <= p_hi_d;
         p_lo_q     <= p_lo_d;
         div_zero_q <= div_zero_d;
      end
   end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: randomized self-checking bench for mult_div against an arithmetic HI/LO model.
module tb_mult_div;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  M_D_Cal;
   logic        is_signed;
   logic [1:0]  Other_Reg_Wr;
   logic [1:0]  M_D_Read;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] MD_out;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   mult_div #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .M_D_Cal(M_D_Cal), .is_signed(is_signed),
      .Other_Reg_Wr(Other_Reg_Wr), .M_D_Read(M_D_Read), .A(A), .B(B),
      .start(start), .busy(busy), .MD_out(MD_out)
   );

   // Architectural result of one command given the current HI/LO.
   function automatic logic [63:0] ref_result(input logic [1:0] cal, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] hi, input logic [31:0] lo);
      int            ia, ib;
      longint        sp;
      logic [63:0]   ua, ub;
      ia = a;
      ib = b;
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (cal)
         2'b01: begin
            if (sgn) begin
               sp = longint'(ia) * longint'(ib);
               return sp;
            end
            return ua * ub;
         end
         2'b10: begin
            if (b == 32'd0) return {hi, lo};
            if (sgn) return {32'(ia % ib), 32'(ia / ib)};
            return {a % b, a / b};
         end
         2'b11: begin
            sp = longint'(ia) * longint'(ib);
            return {hi, lo} + 64'(sp);
         end
         default: return {hi, lo};
      endcase
   endfunction

   function automatic int cycles_of(input logic [1:0] cal);
      return (cal == 2'b10) ? DIV_N : MULT_N;
   endfunction

   // Issue one command, optionally poke inputs while busy, and read HI/LO at the first idle cycle.
   task automatic run_op(input logic [1:0] cal, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] iwr, input logic [1:0] bwr,
                         input logic [1:0] bcal, output bit st, output int nbusy,
                         output bit st_busy, output bit leak,
                         output logic [31:0] hi, output logic [31:0] lo);
      logic [31:0] pre_lo;
      M_D_Cal = 2'b00; Other_Reg_Wr = 2'b00; M_D_Read = 2'b01;
      #1 pre_lo = MD_out;
      M_D_Cal = cal; is_signed = sgn; A = a; B = b; Other_Reg_Wr = iwr;
      #1 st = start;
      @(posedge clk); #1;
      M_D_Cal = 2'b00; Other_Reg_Wr = 2'b00;
      nbusy = 0; st_busy = 1'b0; leak = 1'b0;
      while (busy && nbusy < 50) begin
         nbusy++;
         Other_Reg_Wr = bwr; M_D_Cal = bcal; A = $urandom; B = $urandom; M_D_Read = 2'b01;
         #1;
         if (start) st_busy = 1'b1;
         if (MD_out !== pre_lo) leak = 1'b1;
         @(posedge clk); #1;
         M_D_Cal = 2'b00; Other_Reg_Wr = 2'b00;
      end
      M_D_Read = 2'b10; #1 hi = MD_out;
      M_D_Read = 2'b01; #1 lo = MD_out;
      M_D_Read = 2'b00;
   endtask

   task automatic move(input logic [1:0] wr, input logic [31:0] a);
      M_D_Cal = 2'b00; Other_Reg_Wr = wr; A = a;
      @(posedge clk); #1;
      Other_Reg_Wr = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b1; M_D_Cal = 2'b01; A = $urandom; B = $urandom;
      #1;
      n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
      @(posedge clk); #1;
      reset = 1'b0; M_D_Cal = 2'b00;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      M_D_Read = 2'b10; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", MD_out); end
      M_D_Read = 2'b01; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", MD_out); end
      M_D_Read = 2'b00;
      m_hi = 32'd0; m_lo = 32'd0;
   endtask

   task automatic test_mult();
      logic [31:0] a, b, hi, lo;
      logic        sgn;
      logic [63:0] exp;
      bit          st, sb, lk;
      int          nb;
      for (int i = 0; i < 14; i++) begin
         if (i < 2) begin a = 32'hFFFFFFFE; b = 32'd3; sgn = (i == 0); end
         else begin a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1)); end
         exp = ref_result(2'b01, sgn, a, b, m_hi, m_lo);
         run_op(2'b01, sgn, a, b, 2'b00, 2'b00, 2'b00, st, nb, sb, lk, hi, lo);
         n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL mult_start[%0d]: got %b want 1", i, st); end
         n_cmp++; if (nb !== MULT_N) begin n_err++; $display("FAIL mult_busy[%0d]: got %0d want %0d", i, nb, MULT_N); end
         n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL mult_res[%0d]: got %h want %h", i, {hi, lo}, exp); end
         n_cmp++; if (lk) begin n_err++; $display("FAIL mult_pending_visible[%0d]: got 1 want 0", i); end
         m_hi = exp[63:32]; m_lo = exp[31:0];
      end
   endtask

   task automatic test_div();
      logic [31:0] a, b, hi, lo;
      logic        sgn;
      logic [63:0] exp;
      bit          st, sb, lk;
      int          nb;
      for (int i = 0; i < 14; i++) begin
         if (i == 0) begin a = 32'hFFFFFFF9; b = 32'd2; sgn = 1'b1; end
         else begin
            a = $urandom; sgn = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(1, 100));
            if ($urandom_range(0, 3) == 0) b = 32'(-int'(b));
            if (b == 32'd0) b = 32'd7;
            if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         end
         exp = ref_result(2'b10, sgn, a, b, m_hi, m_lo);
         run_op(2'b10, sgn, a, b, 2'b00, 2'b00, 2'b00, st, nb, sb, lk, hi, lo);
         n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL div_start[%0d]: got %b want 1", i, st); end
         n_cmp++; if (nb !== DIV_N) begin n_err++; $display("FAIL div_busy[%0d]: got %0d want %0d", i, nb, DIV_N); end
         n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL div_res[%0d] a=%h b=%h s=%b: got %h want %h", i, a, b, sgn, {hi, lo}, exp); end
         n_cmp++; if (lk) begin n_err++; $display("FAIL div_pending_visible[%0d]: got 1 want 0", i); end
         m_hi = exp[63:32]; m_lo = exp[31:0];
      end
   endtask

   task automatic test_madd();
      logic [31:0] a, b, hi, lo;
      logic [63:0] exp;
      bit          st, sb, lk;
      int          nb;
      move(2'b10, 32'd1); m_hi = 32'd1;
      move(2'b01, 32'd2); m_lo = 32'd2;
      M_D_Read = 2'b10; #1;
      n_cmp++; if (MD_out !== m_hi) begin n_err++; $display("FAIL mthi: got %h want %h", MD_out, m_hi); end
      M_D_Read = 2'b01; #1;
      n_cmp++; if (MD_out !== m_lo) begin n_err++; $display("FAIL mtlo: got %h want %h", MD_out, m_lo); end
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin a = 32'd2; b = 32'd3; end
         else begin a = $urandom; b = $urandom; end
         exp = ref_result(2'b11, 1'b1, a, b, m_hi, m_lo);
         run_op(2'b11, 1'($urandom_range(0, 1)), a, b, 2'b00, 2'b00, 2'b00, st, nb, sb, lk, hi, lo);
         n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL madd_start[%0d]: got %b want 1", i, st); end
         n_cmp++; if (nb !== MULT_N) begin n_err++; $display("FAIL madd_busy[%0d]: got %0d want %0d", i, nb, MULT_N); end
         n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL madd_res[%0d]: got %h want %h", i, {hi, lo}, exp); end
         m_hi = exp[63:32]; m_lo = exp[31:0];
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] hi, lo;
      bit          st, sb, lk;
      int          nb;
      move(2'b10, 32'h11); move(2'b01, 32'h22);
      m_hi = 32'h11; m_lo = 32'h22;
      run_op(2'b10, 1'b0, $urandom, 32'd0, 2'b00, 2'b01, 2'b00, st, nb, sb, lk, hi, lo);
      n_cmp++; if (nb !== DIV_N) begin n_err++; $display("FAIL divz_busy: got %0d want %0d", nb, DIV_N); end
      n_cmp++; if (hi !== m_hi) begin n_err++; $display("FAIL divz_hi: got %h want %h", hi, m_hi); end
      n_cmp++; if (lo !== m_lo) begin n_err++; $display("FAIL divz_lo: got %h want %h", lo, m_lo); end
      n_cmp++; if (lk) begin n_err++; $display("FAIL divz_mtlo_during_busy: got 1 want 0"); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  cal;
      logic [31:0] a, b, hi, lo;
      logic        sgn;
      logic [63:0] exp;
      bit          st, sb, lk;
      int          nb;
      for (int i = 0; i < 8; i++) begin
         cal = 2'($urandom_range(1, 3)); a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
         if (b == 32'd0) b = 32'd5;
         if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         exp = ref_result(cal, sgn, a, b, m_hi, m_lo);
         run_op(cal, sgn, a, b, 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)),
                st, nb, sb, lk, hi, lo);
         n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL b2b_start[%0d]: got %b want 1", i, st); end
         n_cmp++; if (sb !== 1'b0) begin n_err++; $display("FAIL b2b_start_while_busy[%0d]: got 1 want 0", i); end
         n_cmp++; if (nb !== cycles_of(cal)) begin n_err++; $display("FAIL b2b_busy[%0d]: got %0d want %0d", i, nb, cycles_of(cal)); end
         n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL b2b_res[%0d] cal=%0d: got %h want %h", i, cal, {hi, lo}, exp); end
         m_hi = exp[63:32]; m_lo = exp[31:0];
      end
   endtask

   task automatic test_priority();
      logic [31:0] a, b, hi, lo;
      logic [63:0] exp;
      bit          st, sb, lk;
      int          nb;
      a = $urandom; b = $urandom;
      exp = ref_result(2'b01, 1'b0, a, b, m_hi, m_lo);
      run_op(2'b01, 1'b0, a, b, 2'b01, 2'b00, 2'b00, st, nb, sb, lk, hi, lo);
      n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL cal_over_move: got %h want %h", {hi, lo}, exp); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
      move(2'b11, $urandom);
      M_D_Read = 2'b10; #1;
      n_cmp++; if (MD_out !== m_hi) begin n_err++; $display("FAIL move11_hi: got %h want %h", MD_out, m_hi); end
      M_D_Read = 2'b01; #1;
      n_cmp++; if (MD_out !== m_lo) begin n_err++; $display("FAIL move11_lo: got %h want %h", MD_out, m_lo); end
      M_D_Read = 2'b11; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL read11: got %h want 0", MD_out); end
      M_D_Read = 2'b00; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL read00: got %h want 0", MD_out); end
   endtask

   task automatic test_reset_mid();
      M_D_Cal = 2'b01; is_signed = 1'b0; A = 32'h1234_5678; B = 32'h9abc_def1;
      @(posedge clk); #1;
      M_D_Cal = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      M_D_Read = 2'b10; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL rstmid_hi: got %h want 0", MD_out); end
      M_D_Read = 2'b01; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL rstmid_lo: got %h want 0", MD_out); end
      repeat (12) @(posedge clk);
      #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL rstmid_late_lo: got %h want 0", MD_out); end
      M_D_Read = 2'b10; #1;
      n_cmp++; if (MD_out !== 32'd0) begin n_err++; $display("FAIL rstmid_late_hi: got %h want 0", MD_out); end
      M_D_Read = 2'b00;
      m_hi = 32'd0; m_lo = 32'd0;
   endtask

   initial begin
      reset = 1'b1; M_D_Cal = 2'b00; is_signed = 1'b0; Other_Reg_Wr = 2'b00;
      M_D_Read = 2'b00; A = 32'd0; B = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_mult();
      test_div();
      test_madd();
      test_div_zero();
      test_back_to_back();
      test_priority();
      test_reset_mid();
      test_mult();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy cycles for mult/multu/madd.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port M_D_Cal  input  2  operation command: 00 none, 01 MULT, 10 DIV, 11 MADD.
REQ-006 SHALL have port is_signed  input  1  1 = signed operands for MULT/DIV; ignored for MADD.
REQ-007 SHALL have port Other_Reg_Wr  input  2  move-to command: 00 none, 01 write LO (mtlo), 10 write HI (mthi).
REQ-008 SHALL have port M_D_Read  input  2  read select: 00 none, 01 LO, 10 HI.
REQ-009 SHALL have port A  input  32  rs operand.
REQ-010 SHALL have port B  input  32  rt operand.
REQ-011 SHALL have port start  output  1  combinational; high when a M_D_Cal command is accepted this cycle.
REQ-012 SHALL have port busy  output  1  registered; high while an accepted operation is in progress.
REQ-013 SHALL have port MD_out  output  32  combinational read data.

Function
REQ-014 Command accepted in cycle t iff M_D_Cal != 00, busy = 0, reset = 0; start = that condition.
REQ-015 On acceptance edge: compute result into pending {P_HI,P_LO} from A, B; load down-counter with MULT_CYCLES or DIV_CYCLES; busy = 1 from cycle t+1.
REQ-016 busy SHALL stay high exactly N cycles (t+1..t+N); at edge ending cycle t+N, HI/LO <= P_HI/P_LO and busy <= 0; new values visible at t+N+1.
REQ-017 MULT: {HI,LO} = 64-bit product; signed (two's complement) if is_signed, else unsigned.
REQ-018 DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend A; signed/unsigned per is_signed.
REQ-019 DIV with B = 0: busy runs full DIV_CYCLES; HI and LO SHALL retain previous values.
REQ-020 MADD: {HI,LO} = {HI,LO} + signed(A)*signed(B), 64-bit wrap-around, HI/LO sampled at acceptance.
REQ-021 Other_Reg_Wr with busy = 0: HI or LO <= A at next edge, no busy.
REQ-022 Any M_D_Cal or Other_Reg_Wr while busy = 1 SHALL be ignored (no state change, start = 0); hazard logic stalls such instructions.
REQ-023 M_D_Cal != 00 and Other_Reg_Wr != 00 in same cycle: M_D_Cal wins, move-to ignored.
REQ-024 Other_Reg_Wr = 11 and M_D_Cal with undefined combination SHALL have no effect.
REQ-025 MD_out = LO when M_D_Read = 01, HI when 10, 0 otherwise; reflects committed HI/LO only (pending never visible).
REQ-026 Back-to-back: command may be accepted in cycle t+N+1 (first cycle busy = 0).

Reset
REQ-027 reset high at an edge SHALL set HI = 0, LO = 0, busy = 0, counter = 0, pending discarded; start = 0 while reset high.
REQ-028 Reset mid-operation SHALL abort it; no later HI/LO commit from that operation.

Verification
REQ-029 mult, is_signed=1, A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 mult, is_signed=0, A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-031 div, is_signed=1, A=0xFFFFFFF9, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 mthi A=1, mtlo A=2, then madd A=2, B=3 -> after 5 busy cycles HI=0x00000001, LO=0x00000008; MD_out with M_D_Read=01 = 0x00000008.
REQ-033 divu B=0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged; mtlo issued during busy ignored.
REQ-034 mult accepted, reset asserted in busy cycle 3 -> next cycle busy=0, HI=LO=0, no commit afterwards.
